// File: rtl/time_set_pkg.sv
// time_set_pkg: shared types and constants for the watch time-setting controller.
//   - state_e    : controller FSM states
//   - *_MAX      : wrap limits for hour/minute/second
//   - FLD_*      : bit positions inside blink_mask ({hour, minute, second})
//   - BTN_*      : indices of the three buttons inside the debounced vectors
//   - wrap_step  : +1/-1 with wrap-around inside 0..max
package time_set_pkg;

   typedef enum logic [2:0] {
      RUN     = 3'd0,
      SET_H   = 3'd1,
      SET_M   = 3'd2,
      SET_S   = 3'd3,
      COMMIT  = 3'd4
   } state_e;

   localparam logic [7:0] HOUR_MAX = 8'd23;
   localparam logic [7:0] MIN_MAX  = 8'd59;
   localparam logic [7:0] SEC_MAX  = 8'd59;

   localparam int FLD_HOUR = 2;
   localparam int FLD_MIN  = 1;
   localparam int FLD_SEC  = 0;

   localparam int BTN_DOWN = 0;
   localparam int BTN_UP   = 1;
   localparam int BTN_MODE = 2;

   // Out-of-range values (e.g. a bogus captured time) fold back to 0 on an up step.
   function automatic logic [7:0] wrap_step(input logic [7:0] v, input logic [7:0] max,
                                            input logic up);
      if (up) return (v >= max) ? 8'd0 : v + 8'd1;
      else    return (v == 8'd0) ? max : v - 8'd1;
   endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if: controller <-> clock block / LCD formatter bundle.
//   cur_*      : live time from the clock block (binary)
//   run_en     : clock count enable, low while editing
//   load       : one-cycle pulse, clock block loads set_* on it
//   set_*      : edited time value
//   blink_mask : {hour, minute, second}, 1 = blank field on LCD
//   editing    : high while any field is being edited
// master = the controller, slave = clock block / display side.
interface time_set_ctrl_if;
   logic [7:0] cur_hour;
   logic [7:0] cur_minute;
   logic [7:0] cur_second;
   logic       run_en;
   logic       load;
   logic [7:0] set_hour;
   logic [7:0] set_minute;
   logic [7:0] set_second;
   logic [2:0] blink_mask;
   logic       editing;

   modport master (
      input  cur_hour, cur_minute, cur_second,
      output run_en, load, set_hour, set_minute, set_second, blink_mask, editing
   );

   modport slave (
      output cur_hour, cur_minute, cur_second,
      input  run_en, load, set_hour, set_minute, set_second, blink_mask, editing
   );
endinterface

// File: rtl/time_set_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and press pulse for one raw button.
//   clk, rst : clock, synchronous active-high reset
//   btn_raw  : asynchronous raw button level
//   held     : debounced level has been high for at least two cycles
//   press    : one-cycle pulse, the cycle after the debounced level rises
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic held,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          prev_q, prev_d;
   logic          press_q, press_d;

   always_comb begin
      sync_d  = {sync_q[0], btn_raw};
      cnt_d   = '0;
      level_d = level_q;
      // Counter only advances on consecutive mismatch cycles; flip on the last one.
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_LAST) level_d = ~level_q;
         else                   cnt_d   = cnt_q + 1'b1;
      end
      prev_d  = level_q;
      press_d = level_q & ~prev_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         prev_q  <= prev_d;
         press_q <= press_d;
      end
   end

   assign held  = level_q & prev_q;
   assign press = press_q;
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: manual watch-time setting from three push-buttons.
//   clk, rst          : clock, synchronous active-high reset
//   btn_mode/up/down  : raw asynchronous buttons, active-high
//   tif (master)      : cur_* in; run_en, load, set_*, blink_mask, editing out
// RUN -mode-> SET_H -mode-> SET_M -mode-> SET_S -mode-> COMMIT (1 cycle) -> RUN.
// Optional macro TIME_SET_AUTO_REPEAT_EN: holding up or down in a SET state
// generates extra steps after REPEAT_DELAY cycles, then every REPEAT_RATE cycles.
module time_set_ctrl
   import time_set_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int BLINK_CYCLES    = 12500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_mode,
   input  logic btn_up,
   input  logic btn_down,
   time_set_ctrl_if.master tif
);
   localparam int BW = $clog2(BLINK_CYCLES + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

   logic [2:0] raw, held, press;
   assign raw = {btn_mode, btn_up, btn_down};

   for (genvar i = 0; i < 3; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbc (
         .clk(clk), .rst(rst), .btn_raw(raw[i]), .held(held[i]), .press(press[i])
      );
   end

   state_e        state_q, state_d;
   logic [7:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          phase_q, phase_d;
   logic          editing_w, mode_ev, rpt_up, rpt_dn, step_up, step_dn, step, restart;

   assign editing_w = (state_q == SET_H) || (state_q == SET_M) || (state_q == SET_S);
   assign mode_ev   = press[BTN_MODE];

`ifdef TIME_SET_AUTO_REPEAT_EN
   localparam int RW = $clog2(REPEAT_DELAY + 1);
   logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
   logic          rpt_fire;

   // Holding both buttons, releasing, or a mode event restarts the hold timer.
   always_comb begin
      rpt_fire  = 1'b0;
      rpt_cnt_d = '0;
      if (editing_w && !mode_ev && (held[BTN_UP] ^ held[BTN_DOWN])) begin
         if (rpt_cnt_q == RW'(REPEAT_DELAY - 1)) begin
            rpt_fire  = 1'b1;
            rpt_cnt_d = RW'(REPEAT_DELAY - REPEAT_RATE);
         end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rpt_cnt_q <= '0;
      else     rpt_cnt_q <= rpt_cnt_d;
   end

   assign rpt_up = rpt_fire & held[BTN_UP];
   assign rpt_dn = rpt_fire & held[BTN_DOWN];
`else
   localparam int unused_rpt_params = REPEAT_DELAY + REPEAT_RATE;
   logic unused_held;
   assign unused_held = ^held;
   assign rpt_up = 1'b0;
   assign rpt_dn = 1'b0;
`endif

   // Up and down together cancel each other.
   assign step_up = (press[BTN_UP] | rpt_up) & ~(press[BTN_DOWN] | rpt_dn);
   assign step_dn = (press[BTN_DOWN] | rpt_dn) & ~(press[BTN_UP] | rpt_up);
   assign step    = step_up | step_dn;

   always_comb begin
      state_d     = state_q;
      hour_d      = hour_q;
      min_d       = min_q;
      sec_d       = sec_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      restart     = 1'b0;
      if (editing_w) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
      // Mode is checked first in every SET state so it wins over up/down.
      case (state_q)
         RUN: if (mode_ev) begin
            hour_d  = tif.cur_hour;
            min_d   = tif.cur_minute;
            sec_d   = tif.cur_second;
            state_d = SET_H;
            restart = 1'b1;
         end
         SET_H: begin
            if (mode_ev)   begin state_d = SET_M; restart = 1'b1; end
            else if (step) begin hour_d = wrap_step(hour_q, HOUR_MAX, step_up); restart = 1'b1; end
         end
         SET_M: begin
            if (mode_ev)   begin state_d = SET_S; restart = 1'b1; end
            else if (step) begin min_d = wrap_step(min_q, MIN_MAX, step_up); restart = 1'b1; end
         end
         SET_S: begin
            if (mode_ev)   begin state_d = COMMIT; restart = 1'b1; end
            else if (step) begin sec_d = wrap_step(sec_q, SEC_MAX, step_up); restart = 1'b1; end
         end
         COMMIT:  state_d = RUN;
         default: state_d = RUN;
      endcase
      // Field is shown immediately after entry or a step.
      if (restart) begin
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         hour_q      <= '0;
         min_q       <= '0;
         sec_q       <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         hour_q      <= hour_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
      end
   end

   logic [2:0] mask;
   always_comb begin
      mask = '0;
      case (state_q)
         SET_H:   mask[FLD_HOUR] = phase_q;
         SET_M:   mask[FLD_MIN]  = phase_q;
         SET_S:   mask[FLD_SEC]  = phase_q;
         default: mask = '0;
      endcase
   end

   assign tif.run_en     = (state_q == RUN) || (state_q == COMMIT);
   assign tif.load       = (state_q == COMMIT);
   assign tif.set_hour   = hour_q;
   assign tif.set_minute = min_q;
   assign tif.set_second = sec_q;
   assign tif.blink_mask = mask;
   assign tif.editing    = editing_w;
endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- User-facing controller that sequences manual setting of the watch time (hour/minute/second) from three raw push-buttons.
- Sits between the board buttons and the clock block: freezes counting, edits a shadow copy of the time, commits it with a one-cycle load pulse.
- Drives per-field blink masks to the LCD string formatter so the field being edited flashes.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a button level change (1 ms at 50 MHz).
- BLINK_CYCLES, 12500000, cycles per blink phase (0.25 s at 50 MHz).
- REPEAT_DELAY, 25000000, hold time before auto-repeat starts (AUTO_REPEAT_EN only).
- REPEAT_RATE, 5000000, cycles between auto-repeat steps (AUTO_REPEAT_EN only).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- btn_mode  in  1  raw mode button, asynchronous, active-high.
- btn_up  in  1  raw increment button, asynchronous, active-high.
- btn_down  in  1  raw decrement button, asynchronous, active-high.
- cur_hour  in  8  live hour from the clock block, binary 0..23.
- cur_minute  in  8  live minute, binary 0..59.
- cur_second  in  8  live second, binary 0..59.
- run_en  out  1  clock count enable; 0 while editing.
- load  out  1  one-cycle pulse; the clock block loads set_* on this cycle.
- set_hour  out  8  edited hour value.
- set_minute  out  8  edited minute value.
- set_second  out  8  edited second value.
- blink_mask  out  3  {hour, minute, second}; 1 = blank this field on the LCD.
- editing  out  1  high in any SET_* state.

Behaviour:
- Reset values: run_en=1, load=0, set_*=0, blink_mask=0, editing=0, state=RUN, blink phase=0, debounce counters=0, debounced levels=0.
- Each button passes through a 2-flop synchronizer. A debounced level flips only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle clears the counter. A press event is a 1-cycle pulse on the cycle after the debounced level rises. Releases generate no event.
- FSM states: RUN, SET_H, SET_M, SET_S, COMMIT.
- RUN + mode event: capture cur_* into set_*, run_en<=0, go to SET_H.
- Mode event advances SET_H -> SET_M -> SET_S -> COMMIT.
- COMMIT lasts exactly one cycle: load=1 and run_en=1 are both asserted in that cycle, then the FSM returns to RUN. set_* hold their values after COMMIT.
- Up/down events in SET_x modify only that field, with wrap-around:
  - hour 23+1 -> 0, 0-1 -> 23.
  - minute/second 59+1 -> 0, 0-1 -> 59.
  - The result is registered on the cycle after the event.
- Up/down events in RUN are ignored.
- Simultaneous events:
  - up and down in the same cycle: both ignored.
  - mode with up/down in the same cycle: mode wins and up/down are discarded.
- Blink: a phase counter runs only while editing and toggles the phase every BLINK_CYCLES. On entry to any SET_x, and on every up/down step, the counter and phase reset to 0 so the field is shown immediately.
- blink_mask bit for the active field = phase; other bits are 0. In RUN and COMMIT, blink_mask=0.
- rst mid-edit: immediate return to RUN with reset values. No load is issued and edits are lost.

Optional Feature:
- Macro: TIME_SET_AUTO_REPEAT_EN.
- With the macro: while the debounced up or down level stays high in a SET_x state for REPEAT_DELAY cycles, an extra step event is generated, then one every REPEAT_RATE cycles until release. The repeat counter clears on release, on a state change, or when both buttons are held.
- Without the macro: exactly one step per press; the REPEAT_* parameters are unused.

Decomposition:
- Package time_set_pkg:
  - state enum (RUN, SET_H, SET_M, SET_S, COMMIT).
  - constants HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59.
  - field index constants for blink_mask bit positions.
- Sub-module btn_debounce (synchronizer + stability counter + rising-edge pulse), parameterized by DEBOUNCE_CYCLES, instantiated three times.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, REPEAT_DELAY=20, REPEAT_RATE=5):
- Mode pressed with cur=12:34:56 -> mode event exactly 2+4+1 cycles after the raw edge; then run_en=0, editing=1, set_*=12/34/56, blink_mask=3'b000 for 8 cycles, then 3'b100 for 8 cycles.
- In SET_H at 23, one up press -> set_hour=0. In SET_M at 0, one down press -> set_minute=59. In SET_S at 59, one up press -> set_second=0.
- Full cycle of 4 mode presses -> exactly one load pulse with set_*, run_en returns to 1 in the same cycle, blink_mask=0.
- A 3-cycle glitch on btn_up, then up and down pressed together -> set_hour unchanged; mode and up in the same cycle -> state advances and the field is unchanged.
- rst asserted while in SET_M -> next cycle state=RUN, run_en=1, set_*=0, load never pulses.
- With the macro defined: hold up for 40 cycles in SET_S from 10 -> set_second=15 (1 press + 4 repeats). Without the macro, the same stimulus -> 11.
